ssd_msg_scheduler: RTL and testbench
====================================

# ssd_msg_scheduler

Arbitrates access to the four-digit seven-segment display among several message sources, such as banners ("PLAY", "DEAD"), live score, high score and coin count. Its registered nibble outputs feed the scan controller and display decoder directly. One-shot banners are queued and held for a fixed number of clk_1 ticks. Level-held sources share the display when no banner is pending.

## Interface
Parameters:
- N, 4, number of requesters; index 0 is highest priority.
- HOLD, 2, clk_1 ticks a banner stays on screen; minimum 1.
- ONESHOT_MASK, 4'b0011, bit i=1 makes requester i a one-shot banner; bit i=0 makes it level-held.
- DEFAULT_MSG, 16'h0000, payload shown when nothing is requested.

Ports:
- clk_1  in  1  display-rate clock.
- rst_n  in  1  reset: asynchronous, active-low.
- req  in  N  request lines, sampled on posedge clk_1.
- msg  in  16*N  payload for requester i at msg[16i+:16]; bits [3:0]=ssd_1, [7:4]=ssd_2, [11:8]=ssd_3, [15:12]=ssd_4.
- grant  out  N  one-hot; marks the requester currently on screen; all zero when idle.
- done  out  N  one-cycle pulse when banner i completes.
- busy  out  1  high in any state except IDLE.
- ssd_1, ssd_2, ssd_3, ssd_4  out  4 each  glyph codes to the scan controller.

## Operation
- Edge detect: req_d is the registered copy of req. A banner event on i is req[i] & ~req_d[i] & ONESHOT_MASK[i].
- Banner event with pending[i]=0: set pending[i] and capture msg[i] into the banner buffer for slot i.
- Banner event with pending[i]=1: dropped, including on i's completion cycle. There is no requeue.
- States:
  - IDLE: outputs = DEFAULT_MSG.
  - BANNER: outputs = buffered payload; hold_cnt counts ticks.
  - LEVEL: outputs = live msg[j], re-sampled every tick.
- Selection at every edge, using fixed priority (lowest index wins):
  - If no banner is active and any bit of pending_next is set, pick the lowest pending index. Go to BANNER with hold_cnt=1.
  - Else, if any req[j] is set with ONESHOT_MASK[j]=0, pick the lowest such j. Go to LEVEL.
  - Else go to IDLE.
- BANNER is non-preemptible. When hold_cnt==HOLD at an edge:
  - Clear pending[i] and pulse done[i].
  - Run the selection again in that same edge. The next banner, level source or idle shows with no gap tick.
- LEVEL re-arbitrates every edge:
  - A newly pending banner preempts the level source on the next edge.
  - A higher-priority level request also wins on the next edge.
  - If req[j] drops, the display switches on the next edge.
- grant always matches the source driving the outputs.
- Reset:
  - Asynchronous assertion at any point, including mid-banner.
  - Clears pending, req_d, hold_cnt, grant, done and busy, and sets state to IDLE.
  - ssd_1..ssd_4 take their DEFAULT_MSG nibbles.
  - Banner buffers reset to 0.

## Timing
- Latency from a request sampled at edge k to the display is 0 extra ticks: the outputs change at edge k.
- A banner loaded at edge k has grant high over [k, k+HOLD). At edge k+HOLD, done[i]=1 for exactly one cycle and the next selection takes effect.
- A back-to-back banner pending at completion starts at edge k+HOLD.
- Two banner events at the same edge: the lower index shows first. The higher index follows HOLD ticks later with its payload as captured at that edge.
- hold_cnt width is $clog2(HOLD+1) and it never wraps.
- All outputs are registered; there are no combinational paths from req or msg to the outputs.

## Structure
- Shared package ssd_pkg holds:
  - the state enum (IDLE, BANNER, LEVEL);
  - the glyph constants P=4'hA, L=4'hB, A=4'hC, Y=4'hD, D=4'hE, E=4'hF;
  - MSG_PLAY=16'hABCD and MSG_DEAD=16'hEFCE.
- Sub-module ssd_prio_pick: a parameterized N-bit fixed-priority one-hot picker with an any-valid flag. It is instantiated twice, once for pending banners and once for level requests.

## Test plan
All scenarios use N=4, HOLD=2, ONESHOT_MASK=4'b0011, DEFAULT_MSG=16'h0000.
1. Reset, no requests: ssd=0,0,0,0; grant=0; busy=0. Assert rst_n low mid-banner: outputs return to 0 asynchronously.
2. req[1] rises with msg1=16'hEFCE:
   - The same edge shows E,C,F,E with grant=0010 for 2 ticks.
   - done[1] pulses at the completion edge, then the display goes IDLE.
3. req[0] (msg=16'hABCD) and req[1] (msg=16'hEFCE) rise together:
   - PLAY shows for 2 ticks, then DEAD for 2 ticks.
   - done[0] and done[1] pulse 2 ticks apart.
4. req[2] held with msg2=16'h0123: display tracks msg2 each tick.
   - Change msg2 to 16'h0456: the new value shows on the next edge.
   - Pulse req[0]: PLAY preempts next edge, holds 2 ticks, then req[2]'s payload resumes.
5. req[3] and req[2] both held: grant=0100. Drop req[2]: grant=1000 on the next edge.
6. Re-pulse req[1] during its own banner, including on the completion edge: exactly one done[1] pulse, with no second display.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment message scheduler.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BANNER,
    LEVEL
  } state_t;

  localparam logic [3:0] GLYPH_P = 4'hA;
  localparam logic [3:0] GLYPH_L = 4'hB;
  localparam logic [3:0] GLYPH_A = 4'hC;
  localparam logic [3:0] GLYPH_Y = 4'hD;
  localparam logic [3:0] GLYPH_D = 4'hE;
  localparam logic [3:0] GLYPH_E = 4'hF;

  // Digit 4 is leftmost, so the word reads from the top nibble down.
  localparam logic [15:0] MSG_PLAY = {GLYPH_P, GLYPH_L, GLYPH_A, GLYPH_Y};
  localparam logic [15:0] MSG_DEAD = {GLYPH_D, GLYPH_E, GLYPH_A, GLYPH_D};

endpackage

// File: rtl/ssd_msg_scheduler_if.sv
// Request/payload bundle and display outputs of the message scheduler.
interface ssd_msg_scheduler_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [16*N-1:0] msg;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [3:0]      ssd_1;
  logic [3:0]      ssd_2;
  logic [3:0]      ssd_3;
  logic [3:0]      ssd_4;

  modport master (
    output req, msg,
    input  grant, done, busy, ssd_1, ssd_2, ssd_3, ssd_4
  );

  modport slave (
    input  req, msg,
    output grant, done, busy, ssd_1, ssd_2, ssd_3, ssd_4
  );
endinterface

// File: rtl/ssd_prio_pick.sv
// Fixed-priority one-hot picker: lowest set index wins.
module ssd_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);
  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + N'(1));
  assign any = |req;
endmodule

// File: rtl/ssd_msg_scheduler.sv
// Arbitrates the four-digit display between queued one-shot banners and level-held sources.
module ssd_msg_scheduler
  import ssd_pkg::*;
#(
  parameter int          N            = 4,
  parameter int          HOLD         = 2,
  parameter logic [N-1:0] ONESHOT_MASK = N'(4'b0011),
  parameter logic [15:0] DEFAULT_MSG  = 16'h0000
) (
  input logic                 clk_1,
  input logic                 rst_n,
  ssd_msg_scheduler_if.slave  bus
);
  localparam int CW = $clog2(HOLD + 1);

  state_t         state;
  logic [CW-1:0]  hold_cnt;
  logic [N-1:0]   req_d, pending, grant_q, done_q;
  logic [15:0]    buf_q [N];
  logic [15:0]    ssd_q;
  logic           busy_q;

  logic [N-1:0]   accept, clear, pending_next, level_req;
  logic [N-1:0]   ban_oh, lvl_oh;
  logic           ban_any, lvl_any, completing, banner_hold;
  logic [15:0]    buf_next [N];
  logic [15:0]    ban_msg, lvl_msg;

  // A repeat event while still pending is dropped, even on the completion edge.
  assign accept       = bus.req & ~req_d & ONESHOT_MASK & ~pending;
  assign completing   = (state == BANNER) && (hold_cnt == CW'(HOLD));
  assign banner_hold  = (state == BANNER) && !completing;
  assign clear        = completing ? grant_q : '0;
  assign pending_next = (pending & ~clear) | accept;
  assign level_req    = bus.req & ~ONESHOT_MASK;

  ssd_prio_pick #(.N(N)) u_ban_pick (.req(pending_next), .gnt(ban_oh), .any(ban_any));
  ssd_prio_pick #(.N(N)) u_lvl_pick (.req(level_req),    .gnt(lvl_oh), .any(lvl_any));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    ban_msg = '0;
    lvl_msg = '0;
    for (int i = 0; i < N; i++) begin
      // A banner starting on its own event edge must see the payload being captured now.
      buf_next[i] = accept[i] ? bus.msg[16*i +: 16] : buf_q[i];
      if (ban_oh[i]) ban_msg = ban_msg | buf_next[i];
      if (lvl_oh[i]) lvl_msg = lvl_msg | bus.msg[16*i +: 16];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      req_d    <= '0;
      pending  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      ssd_q    <= DEFAULT_MSG;
      // NOTE: the banner buffers are small and architecturally reset, so they are cleared here too.
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      req_d   <= bus.req;
      pending <= pending_next;
      done_q  <= clear;
      for (int i = 0; i < N; i++) buf_q[i] <= buf_next[i];

      if (banner_hold) begin
        hold_cnt <= hold_cnt + CW'(1);
      end else if (ban_any) begin
        state    <= BANNER;
        hold_cnt <= CW'(1);
        grant_q  <= ban_oh;
        ssd_q    <= ban_msg;
        busy_q   <= 1'b1;
      end else if (lvl_any) begin
        state    <= LEVEL;
        hold_cnt <= '0;
        grant_q  <= lvl_oh;
        ssd_q    <= lvl_msg;
        busy_q   <= 1'b1;
      end else begin
        state    <= IDLE;
        hold_cnt <= '0;
        grant_q  <= '0;
        ssd_q    <= DEFAULT_MSG;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.ssd_1 = ssd_q[3:0];
  assign bus.ssd_2 = ssd_q[7:4];
  assign bus.ssd_3 = ssd_q[11:8];
  assign bus.ssd_4 = ssd_q[15:12];

endmodule

// File: tb/tb_ssd_msg_scheduler.sv
// Directed scoreboard bench for ssd_msg_scheduler (N=4, HOLD=2, ONESHOT_MASK=0011).
module tb_ssd_msg_scheduler;
  import ssd_pkg::*;

  typedef struct {
    string       tag;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] ssd;
  } exp_t;

  logic clk_1 = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  ssd_msg_scheduler_if #(.N(4)) bus ();

  ssd_msg_scheduler #(
    .N(4), .HOLD(2), .ONESHOT_MASK(4'b0011), .DEFAULT_MSG(16'h0000)
  ) dut (
    .clk_1(clk_1),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk_1 = ~clk_1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".grant"}, 16'(bus.grant), 16'(e.grant));
    check({e.tag, ".done"},  16'(bus.done),  16'(e.done));
    check({e.tag, ".busy"},  16'(bus.busy),  16'(e.busy));
    check({e.tag, ".ssd"},   {bus.ssd_4, bus.ssd_3, bus.ssd_2, bus.ssd_1}, e.ssd);
  endtask

  // Push the expectation for the upcoming edge, then compare just after it.
  task automatic cycle(input string tag, input logic [3:0] g, input logic [3:0] d,
                       input logic b, input logic [15:0] s);
    sb.push_back('{tag, g, d, b, s});
    @(posedge clk_1);
    #1;
    compare_head();
  endtask

  task automatic expect_now(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic b, input logic [15:0] s);
    sb.push_back('{tag, g, d, b, s});
    compare_head();
  endtask

  task automatic set_msg(input int i, input logic [15:0] v);
    bus.msg[16*i +: 16] = v;
  endtask

  initial begin
    bus.req = '0;
    bus.msg = '0;
    #12;
    expect_now("rst", 4'b0000, 4'b0000, 1'b0, 16'h0000);
    rst_n = 1'b1;
    cycle("idle", 4'b0000, 4'b0000, 1'b0, 16'h0000);

    // Single banner on requester 1
    set_msg(1, MSG_DEAD);
    bus.req[1] = 1'b1;
    cycle("t2_show", 4'b0010, 4'b0000, 1'b1, 16'hEFCE);
    bus.req[1] = 1'b0;
    cycle("t2_hold", 4'b0010, 4'b0000, 1'b1, 16'hEFCE);
    cycle("t2_done", 4'b0000, 4'b0010, 1'b0, 16'h0000);
    cycle("t2_idle", 4'b0000, 4'b0000, 1'b0, 16'h0000);

    // Simultaneous banners; payload of 1 must be the one captured at the shared edge
    set_msg(0, MSG_PLAY);
    bus.req = 4'b0011;
    cycle("t3_play1", 4'b0001, 4'b0000, 1'b1, 16'hABCD);
    bus.req = 4'b0000;
    set_msg(1, 16'h1111);
    cycle("t3_play2", 4'b0001, 4'b0000, 1'b1, 16'hABCD);
    cycle("t3_dead1", 4'b0010, 4'b0001, 1'b1, 16'hEFCE);
    cycle("t3_dead2", 4'b0010, 4'b0000, 1'b1, 16'hEFCE);
    cycle("t3_done",  4'b0000, 4'b0010, 1'b0, 16'h0000);

    // Level source tracking and preemption by a banner
    set_msg(2, 16'h0123);
    bus.req = 4'b0100;
    cycle("t4_lvl1",  4'b0100, 4'b0000, 1'b1, 16'h0123);
    cycle("t4_lvl2",  4'b0100, 4'b0000, 1'b1, 16'h0123);
    set_msg(2, 16'h0456);
    cycle("t4_track", 4'b0100, 4'b0000, 1'b1, 16'h0456);
    bus.req[0] = 1'b1;
    cycle("t4_pre",   4'b0001, 4'b0000, 1'b1, 16'hABCD);
    bus.req[0] = 1'b0;
    cycle("t4_hold",  4'b0001, 4'b0000, 1'b1, 16'hABCD);
    cycle("t4_resume",4'b0100, 4'b0001, 1'b1, 16'h0456);

    // Two level sources, then the higher-priority one drops
    set_msg(3, 16'h0789);
    bus.req = 4'b1100;
    cycle("t5_both", 4'b0100, 4'b0000, 1'b1, 16'h0456);
    bus.req[2] = 1'b0;
    cycle("t5_drop", 4'b1000, 4'b0000, 1'b1, 16'h0789);
    bus.req = 4'b0000;
    cycle("t5_idle", 4'b0000, 4'b0000, 1'b0, 16'h0000);

    // Re-pulse during own banner, landing on the completion edge
    set_msg(1, MSG_DEAD);
    bus.req[1] = 1'b1;
    cycle("t6_show", 4'b0010, 4'b0000, 1'b1, 16'hEFCE);
    bus.req[1] = 1'b0;
    cycle("t6_hold", 4'b0010, 4'b0000, 1'b1, 16'hEFCE);
    bus.req[1] = 1'b1;
    cycle("t6_done", 4'b0000, 4'b0010, 1'b0, 16'h0000);
    bus.req[1] = 1'b0;
    cycle("t6_none1", 4'b0000, 4'b0000, 1'b0, 16'h0000);
    cycle("t6_none2", 4'b0000, 4'b0000, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of a banner
    bus.req[0] = 1'b1;
    cycle("t7_show", 4'b0001, 4'b0000, 1'b1, 16'hABCD);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("t7_async", 4'b0000, 4'b0000, 1'b0, 16'h0000);
    bus.req = 4'b0000;
    #3;
    rst_n = 1'b1;
    cycle("t7_after", 4'b0000, 4'b0000, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
